// File: rtl/sata_link_seq.sv
// sata_link_seq: per-port SATA PHY bring-up sequencer with timed phyreset, StartComm, link timeout/retry,
// backoff and debounced link-loss recovery; all status outputs are registered.
module sata_link_seq #(
    parameter int unsigned C_RST_CYCLES = 64,
    parameter int unsigned C_LINK_TMO   = 750000,
    parameter int unsigned C_BACKOFF    = 75000,
    parameter int unsigned C_MAX_RETRY  = 7,
    parameter int unsigned C_DEBOUNCE   = 16,
    parameter int unsigned C_TMR_W      = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       restart,
    input  logic       plllock,
    input  logic       linkup,
    input  logic       CommInit,
    output logic       phyreset,
    output logic       StartComm,
    output logic       link_ready,
    output logic       link_fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] seq_state,
    output logic       comm_seen
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLLWAIT  = 3'd1,
        S_RESET    = 3'd2,
        S_START    = 3'd3,
        S_WAITLINK = 3'd4,
        S_READY    = 3'd5,
        S_BACKOFF  = 3'd6,
        S_FAIL     = 3'd7
    } state_t;

    localparam int unsigned L_DBW = $clog2(C_DEBOUNCE + 1);
    localparam logic [C_TMR_W-1:0] L_RST_LD = C_TMR_W'(C_RST_CYCLES - 1);
    localparam logic [C_TMR_W-1:0] L_TMO_LD = C_TMR_W'(C_LINK_TMO - 1);
    localparam logic [C_TMR_W-1:0] L_BO_LD  = C_TMR_W'(C_BACKOFF - 1);

    state_t             r_state, w_next;
    logic [C_TMR_W-1:0] r_timer, w_tload;
    logic [L_DBW-1:0]   r_dbc;
    logic [3:0]         r_retry, w_retry_inc;
    logic               r_phyreset, r_startcomm, r_ready, r_fail, r_comm;
    logic               w_phyreset, w_startcomm, w_ready, w_fail;
    logic               w_tmo, w_dbc_hit, w_restart, w_enter, w_timeout_step;

    // Timers are loaded with N-1 so each timed state lasts exactly N cycles.
    assign w_tmo       = r_timer == '0;
    assign w_retry_inc = (r_retry == 4'd15) ? r_retry : r_retry + 4'd1;
    assign w_dbc_hit   = !linkup && r_dbc == L_DBW'(C_DEBOUNCE - 1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = enable ? S_PLLWAIT : S_IDLE;
            S_PLLWAIT:  w_next = plllock ? S_RESET : S_PLLWAIT;
            S_RESET:    w_next = w_tmo ? S_START : S_RESET;
            S_START:    w_next = S_WAITLINK;
            S_WAITLINK: w_next = linkup ? S_READY : !w_tmo ? S_WAITLINK :
                                 (w_retry_inc == 4'(C_MAX_RETRY)) ? S_FAIL : S_BACKOFF;
            S_READY:    w_next = w_dbc_hit ? S_RESET : S_READY;
            S_BACKOFF:  w_next = w_tmo ? S_RESET : S_BACKOFF;
            default:    w_next = S_FAIL;
        endcase
        if (restart && r_state != S_IDLE)
            w_next = S_RESET;
        if (!plllock && r_state != S_IDLE && r_state != S_FAIL)
            w_next = S_PLLWAIT;
        if (!enable)
            w_next = S_IDLE;
    end

    // A restart from inside RESET counts as a fresh entry (timer reload, comm_seen clear).
    assign w_restart      = restart && r_state != S_IDLE && w_next == S_RESET;
    assign w_enter        = w_next != r_state || w_restart;
    assign w_timeout_step = r_state == S_WAITLINK && (w_next == S_FAIL || w_next == S_BACKOFF);

    always_comb begin
        w_phyreset  = w_next == S_IDLE || w_next == S_PLLWAIT || w_next == S_RESET || w_next == S_FAIL;
        w_startcomm = w_next == S_START;
        w_ready     = w_next == S_READY;
        w_fail      = w_next == S_FAIL;
        w_tload     = w_next == S_RESET ? L_RST_LD : w_next == S_WAITLINK ? L_TMO_LD :
                      w_next == S_BACKOFF ? L_BO_LD : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_dbc       <= '0;
            r_retry     <= '0;
            r_comm      <= 1'b0;
            r_phyreset  <= 1'b1;
            r_startcomm <= 1'b0;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_timer     <= w_enter ? w_tload : w_tmo ? r_timer : r_timer - 1'b1;
            r_dbc       <= (r_state == S_READY && !linkup) ? r_dbc + 1'b1 : '0;
            r_retry     <= (w_next == S_IDLE || w_next == S_READY || w_restart) ? 4'd0 :
                           w_timeout_step ? w_retry_inc : r_retry;
            r_comm      <= (w_enter && w_next == S_RESET) ? 1'b0 : r_comm | CommInit;
            r_phyreset  <= w_phyreset;
            r_startcomm <= w_startcomm;
            r_ready     <= w_ready;
            r_fail      <= w_fail;
        end
    end

    assign phyreset   = r_phyreset;
    assign StartComm  = r_startcomm;
    assign link_ready = r_ready;
    assign link_fail  = r_fail;
    assign retry_cnt  = r_retry;
    assign seq_state  = r_state;
    assign comm_seen  = r_comm;
endmodule
